// File: rtl/pipe_skid_stage.sv
// Elastic pipeline-stage register with a 2-entry skid buffer, synchronous flush,
// optional bubble data gating and saturating bubble/stall counters.
//
// state   | meaning
// --------+-----------------------------------------------
// S_EMPTY | nothing held; out_valid=0, in_ready=1
// S_ONE   | main entry valid; skid empty; in_ready=1
// S_FULL  | main and skid entries valid; in_ready=0
module pipe_skid_stage #(
   parameter int DATA_W       = 71,
   parameter bit GATE_BUBBLES = 1'b1,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  bubble_cnt,
   output logic [CNT_W-1:0]  stall_cnt
);

   // bit 0 is main_valid, bit 1 is skid_valid
   localparam logic [1:0] S_EMPTY = 2'b00;
   localparam logic [1:0] S_ONE   = 2'b01;
   localparam logic [1:0] S_FULL  = 2'b11;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]        state, state_nxt;
   logic [DATA_W-1:0] main_data, main_nxt;
   logic [DATA_W-1:0] skid_data, skid_nxt;
   logic              ready_q;
   logic              accept, fire;

   assign in_ready  = ready_q;
   assign out_valid = state[0];
   assign out_data  = main_data;
   assign accept    = in_valid & ready_q;
   assign fire      = state[0] & out_ready;

   always_comb begin
      state_nxt = state;
      main_nxt  = main_data;
      skid_nxt  = skid_data;
      case (state)
         S_EMPTY: begin
            if (accept) begin
               state_nxt = S_ONE;
               main_nxt  = in_data;
            end else if (!GATE_BUBBLES) begin
               main_nxt  = in_data;
            end
         end
         S_ONE: begin
            if (accept && fire) begin
               main_nxt  = in_data;
            end else if (accept) begin
               state_nxt = S_FULL;
               skid_nxt  = in_data;
            end else if (fire) begin
               state_nxt = S_EMPTY;
            end
         end
         S_FULL: begin
            if (fire) begin
               state_nxt = S_ONE;
               main_nxt  = skid_data;
            end
         end
         default: state_nxt = S_EMPTY;
      endcase
      // flush discards everything in flight but leaves the data registers alone
      if (flush) begin
         state_nxt = S_EMPTY;
         main_nxt  = main_data;
         skid_nxt  = skid_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_EMPTY;
         main_data <= '0;
         skid_data <= '0;
         ready_q   <= 1'b1;
      end else begin
         state     <= state_nxt;
         main_data <= main_nxt;
         skid_data <= skid_nxt;
         ready_q   <= ~state_nxt[1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bubble_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         if (!state[0] && bubble_cnt != CNT_MAX)
            bubble_cnt <= bubble_cnt + 1'b1;
         if (state[0] && !out_ready && stall_cnt != CNT_MAX)
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: streaming, back-pressure, flush,
// bubble gating, counter saturation and asynchronous reset.
module tb_pipe_skid_stage;

   localparam int DW = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] bubble_cnt;
   logic [CW-1:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   pipe_skid_stage #(.DATA_W(DW), .GATE_BUBBLES(1'b1), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // loads 0x0A then 0x0B with out_ready low, leaving the stage FULL
   task automatic fill_full;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h0A;
      tick();
      in_data   = 8'h0B;
      tick();
      in_valid  = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++;
      if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++;
      if (bubble_cnt !== 4'd0 || stall_cnt !== 4'd0) begin
         errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", bubble_cnt, stall_cnt);
      end
   endtask

   task automatic test_stream;
      do_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h01;
      for (int i = 1; i <= 5; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== DW'(i)) begin
            errors++; $display("FAIL stream_%0d: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, DW'(i));
         end
         if (i < 5) in_data = DW'(i + 1);
         else in_valid = 1'b0;
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b expected 0", out_valid); end
      checks++;
      if (stall_cnt !== 4'd0) begin errors++; $display("FAIL stream_stall_cnt: got %0d expected 0", stall_cnt); end
   endtask

   task automatic test_backpressure;
      do_reset();
      fill_full();
      checks++;
      if (in_ready !== 1'b0 || out_data !== 8'h0A || stall_cnt !== 4'd1) begin
         errors++; $display("FAIL bp_full: got rdy=%b d=%h stall=%0d expected rdy=0 d=0a stall=1", in_ready, out_data, stall_cnt);
      end
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++;
         if (out_data !== 8'h0A || in_ready !== 1'b0 || stall_cnt !== CW'(1 + k)) begin
            errors++; $display("FAIL bp_hold_%0d: got d=%h rdy=%b stall=%0d expected d=0a rdy=0 stall=%0d", k, out_data, in_ready, stall_cnt, 1 + k);
         end
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h0B || in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release: got v=%b d=%h rdy=%b expected v=1 d=0b rdy=1", out_valid, out_data, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || stall_cnt !== 4'd4) begin
         errors++; $display("FAIL bp_drain: got v=%b stall=%0d expected v=0 stall=4", out_valid, stall_cnt);
      end
   endtask

   task automatic test_flush;
      do_reset();
      fill_full();
      in_valid = 1'b1;
      in_data  = 8'h0C;
      flush    = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL flush_empty: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_no_deliver_%0d: got v=%b d=%h expected v=0", k, out_valid, out_data);
         end
      end
   endtask

   task automatic test_bubble_gating;
      do_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h55;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h55) begin
         errors++; $display("FAIL gate_deliver: got v=%b d=%h expected v=1 d=55", out_valid, out_data);
      end
      in_valid = 1'b0;
      in_data  = 8'hAA;
      tick();
      for (int k = 1; k <= 5; k++) begin
         in_data = DW'($urandom);
         tick();
         checks++;
         if (out_valid !== 1'b0 || out_data !== 8'h55 || bubble_cnt !== CW'(1 + k)) begin
            errors++; $display("FAIL gate_idle_%0d: got v=%b d=%h bub=%0d expected v=0 d=55 bub=%0d", k, out_valid, out_data, bubble_cnt, 1 + k);
         end
      end
   endtask

   task automatic test_saturation;
      do_reset();
      for (int i = 1; i <= 20; i++) begin
         tick();
         checks++;
         if (bubble_cnt !== CW'((i > 15) ? 15 : i)) begin
            errors++; $display("FAIL sat_%0d: got %0d expected %0d", i, bubble_cnt, (i > 15) ? 15 : i);
         end
      end
   endtask

   task automatic test_async_reset;
      do_reset();
      fill_full();
      #3 reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
         errors++; $display("FAIL areset_outputs: got v=%b rdy=%b d=%h expected v=0 rdy=1 d=00", out_valid, in_ready, out_data);
      end
      checks++;
      if (bubble_cnt !== 4'd0 || stall_cnt !== 4'd0) begin
         errors++; $display("FAIL areset_counters: got %0d/%0d expected 0/0", bubble_cnt, stall_cnt);
      end
      #1 reset  = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h3C;
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
         errors++; $display("FAIL areset_resume: got v=%b d=%h expected v=1 d=3c", out_valid, out_data);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_bubble_gating();
      test_saturation();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised elastic pipeline-stage register; next generation of the fixed MEM/WB latch.
- Carries an arbitrary-width payload between two pipeline stages with a valid/ready handshake and a 2-entry skid buffer, so back-pressure never forces a combinational ready path.
- Adds synchronous flush, optional bubble data gating for power, and saturating bubble/stall performance counters.
- Instantiated between MEM and WB, and reusable at any other stage boundary.

Parameters:
- DATA_W, 71, payload width in bits (default = rd 5 + control 2 + result 32 + read data 32).
- GATE_BUBBLES, 1, 1 = data registers load only on accepted transfers; 0 = main data register tracks in_data while the stage is empty.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept a payload this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  payload presented downstream.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  DATA_W  payload to downstream.
- bubble_cnt  output  CNT_W  cycles with out_valid=0, saturating.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Interface is decided: one clock, clk; reset is asynchronous and active-high.
- Reset clears all of the following:
  - main_valid, skid_valid, main_data, skid_data and both counters go to 0.
  - out_valid=0, out_data=0, in_ready=1.
- Event definitions:
  - in_ready = !skid_valid, driven directly from a flop.
  - out_valid = main_valid.
  - out_data = main_data.
  - accept = in_valid & in_ready.
  - fire = out_valid & out_ready.
- States:
  - EMPTY: main_valid=0, skid_valid=0.
  - ONE: main_valid=1, skid_valid=0.
  - FULL: main_valid=1, skid_valid=1.
- EMPTY transitions:
  - accept -> ONE, main_data<=in_data.
  - no accept -> stay in EMPTY.
- ONE transitions:
  - accept & fire -> ONE, main_data<=in_data.
  - accept & !fire -> FULL, skid_data<=in_data.
  - !accept & fire -> EMPTY.
  - neither -> hold.
- FULL transitions:
  - in_ready=0, so no accept is possible.
  - fire -> ONE, main_data<=skid_data.
  - no fire -> hold.
- Latency and throughput:
  - Latency is 1 cycle from accept to out_valid when the stage is EMPTY.
  - Throughput is 1 payload/cycle under continuous out_ready=1.
- Ordering: payloads leave in acceptance order, with no loss and no duplication.
- Flush:
  - Highest priority; takes effect at the next edge.
  - main_valid and skid_valid go to 0, so state becomes EMPTY.
  - A payload presented in the same cycle is discarded even if in_valid & in_ready.
  - A fire in the flush cycle still counts as delivered downstream; the stage does not undo it.
  - Data registers are not cleared by flush.
- Bubble gating:
  - GATE_BUBBLES=1: main_data and skid_data change only on the transitions listed above; out_data holds its last value while out_valid=0.
  - GATE_BUBBLES=0: in EMPTY with no flush, main_data<=in_data every cycle.
- Counters:
  - Sampled from pre-edge values.
  - Each saturates at 2^CNT_W-1 and does not wrap.
  - Cleared only by reset.
- Upstream protocol:
  - Upstream holds in_data stable while in_valid=1 and in_ready=0.
  - The stage never drops a payload that was accepted and not flushed.
- Reset asserted mid-transfer takes effect immediately (asynchronously): outputs go to reset values without waiting for a clock edge.

Test Plan:
- Reset then stream: drive in_data=0x01..0x05 on consecutive cycles with in_valid=1 and out_ready=1 -> out_data 0x01..0x05 on consecutive cycles, each 1 cycle after its accept; stall_cnt=0.
- Back-pressure:
  - Stimulus: accept 0xA then 0xB with out_ready=0, then hold out_ready=0 for 3 cycles.
  - Required: in_ready=0 after the second accept; out_data=0xA throughout; stall_cnt increments by 1 per stalled cycle.
  - Then raise out_ready: 0xA then 0xB delivered, in_ready returns to 1.
- Flush while FULL with in_valid=1, in_data=0xC -> next cycle out_valid=0 and in_ready=1; 0xA, 0xB and 0xC are never delivered.
- Bubble gating, GATE_BUBBLES=1: deliver 0x55, then in_valid=0 with in_data toggling randomly -> out_data stays 0x55 and bubble_cnt increments each idle cycle.
- Counter saturation, CNT_W=4: 20 idle cycles -> bubble_cnt=15 and stays 15.
- Asynchronous reset asserted between edges while FULL -> out_valid=0 and in_ready=1 immediately (before the next edge), counters=0; after release, normal acceptance resumes.
